// File: rtl/instr_encoder.sv
// instr_encoder
//   Pipelined RV32I instruction encoder. Takes decoded fields and a signed
//   32-bit immediate, range-checks the immediate for the selected format,
//   scatters its bits into the instruction word, and tags each word with a
//   sequential word address for instruction-memory preload.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   clear            synchronous: address counter -> BASE_ADDR, err_count -> 0
//   in_valid/in_ready     input handshake
//   imm_sel          000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 11x illegal
//   opcode, rd, rs1, rs2, funct3, funct7, immediate   decoded fields
//   out_valid/out_ready   output handshake
//   out_instr        encoded word
//   out_addr         word address of out_instr
//   out_err          immediate out of range or illegal imm_sel
//   err_count        saturating count of accepted erroring words
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_sel,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  function automatic logic [31:0] encode(
    input logic [2:0]  sel,
    input logic [6:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'd0;
    case (sel)
      3'b000: w = {imm[11:0], f_rs1, f3, f_rd, op};
      3'b001: w = {imm[11:5], f_rs2, f_rs1, f3, imm[4:0], op};
      3'b010: w = {imm[12], imm[10:5], f_rs2, f_rs1, f3, imm[4:1], imm[11], op};
      3'b011: w = {imm[31:12], f_rd, op};
      3'b100: w = {imm[20], imm[10:1], imm[11], imm[19:12], f_rd, op};
      3'b101: w = {f7, f_rs2, f_rs1, f3, f_rd, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // An immediate fits when every bit above the field's sign bit equals it.
  function automatic logic range_err(input logic [2:0] sel, input logic [31:0] imm);
    logic e;
    e = 1'b1;
    case (sel)
      3'b000, 3'b001: e = !((&imm[31:11]) || !(|imm[31:11]));
      3'b010:         e = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'b011:         e = |imm[11:0];
      3'b100:         e = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      3'b101:         e = 1'b0;
      default:        e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic              vld_p1;
  logic [31:0]       instr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              err_p1;
  logic [7:0]        err_cnt;
  logic [ADDR_W-1:0] cnt;

  logic        accept;
  logic [31:0] enc_instr_p0;
  logic        enc_err_p0;

  // Stage p0: combinational encode and range check of the presented fields
  assign in_ready     = !rst && (!vld_p1 || out_ready);
  assign accept       = in_valid && in_ready;
  assign enc_instr_p0 = encode(imm_sel, opcode, rd, rs1, rs2, funct3, funct7, immediate);
  assign enc_err_p0   = range_err(imm_sel, immediate);

  // Stage p1: output register, address counter and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= 32'd0;
      addr_p1  <= '0;
      err_p1   <= 1'b0;
      err_cnt  <= 8'd0;
      cnt      <= BASE;
    end else begin
      if (accept)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;

      if (accept) begin
        instr_p1 <= enc_instr_p0;
        err_p1   <= enc_err_p0;
        addr_p1  <= clear ? BASE : cnt;
      end

      // clear coinciding with an accept hands that word BASE, so the
      // counter must already point past it.
      if (clear)
        cnt <= accept ? BASE + ADDR_W'(1) : BASE;
      else if (accept)
        cnt <= cnt + ADDR_W'(1);

      if (clear)
        err_cnt <= {7'd0, accept && enc_err_p0};
      else if (accept && enc_err_p0)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;
  assign out_err   = err_p1;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder: reset values, every format against
//   hand-encoded words, range errors, stall/hold, address wrap and clear on a
//   narrow-counter instance, asynchronous reset mid-stall, and a random
//   round-trip through a small decoder model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, clear2;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [2:0]  imm_sel;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immediate;
  logic        out_valid, out_valid2;
  logic        out_ready, out_ready2;
  logic [31:0] out_instr, out_instr2;
  logic [9:0]  out_addr;
  logic [1:0]  out_addr2;
  logic        out_err, out_err2;
  logic [7:0]  err_count, err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] f_rd,
                            input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    imm_sel = sel; opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
    funct3 = f3; funct7 = f7; immediate = imm;
  endtask

  // Present one word to dut and return #1 after the edge that accepts it.
  task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] f_rd,
                      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n;
    set_fields(sel, op, f_rd, f_rs1, f_rs2, f3, f7, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] dec_imm(input logic [2:0] sel, input logic [31:0] w);
    logic [31:0] r;
    r = 32'd0;
    case (sel)
      3'd0: r = {{20{w[31]}}, w[31:20]};
      3'd1: r = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3: r = {w[31:12], 12'd0};
      3'd4: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  exp_a[5];
    logic [1:0]  exp_c[5];
    logic [31:0] w0;
    logic [31:0] rnd;
    logic [2:0]  sel;
    logic [31:0] imm;
    int v;

    rst = 1'b1; clear = 1'b0; clear2 = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    // ---------------- reset values
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {22'd0, out_addr}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // ---------------- directed formats
    send(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("i_valid", {31'd0, out_valid}, 32'd1);
    chk("i_instr", out_instr, 32'hFFF10093);
    chk("i_addr", {22'd0, out_addr}, 32'd0);
    chk("i_err", {31'd0, out_err}, 32'd0);

    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("b_instr", out_instr, 32'hFE208EE3);
    chk("b_addr", {22'd0, out_addr}, 32'd1);
    chk("b_err", {31'd0, out_err}, 32'd0);

    send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    chk("b_odd_err", {31'd0, out_err}, 32'd1);
    chk("b_odd_instr", out_instr, 32'h00208163);
    chk("b_odd_errcnt", {24'd0, err_count}, 32'd1);

    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("j_instr", out_instr, 32'h001000EF);
    chk("j_err", {31'd0, out_err}, 32'd0);

    send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    chk("u_err", {31'd0, out_err}, 32'd1);
    chk("u_instr", out_instr, 32'h123452B7);
    chk("u_errcnt", {24'd0, err_count}, 32'd2);

    send(3'd5, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hDEAD_BEEF);
    chk("r_instr", out_instr, 32'h403100B3);
    chk("r_err", {31'd0, out_err}, 32'd0);

    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    chk("s_instr", out_instr, 32'h0020A423);
    chk("s_addr", {22'd0, out_addr}, 32'd6);

    send(3'd6, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("ill_instr", out_instr, 32'd0);
    chk("ill_err", {31'd0, out_err}, 32'd1);

    send(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("i_big_err", {31'd0, out_err}, 32'd1);
    chk("i_big_instr", out_instr, 32'h80010093);
    chk("i_big_errcnt", {24'd0, err_count}, 32'd4);

    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- clear, then stalled back-to-back stream
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_errcnt", {24'd0, err_count}, 32'd0);

    send(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
    w0 = 32'h00110093;
    chk("st0_instr", out_instr, w0);
    chk("st0_addr", {22'd0, out_addr}, 32'd0);
    out_ready = 1'b0;
    set_fields(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
    in_valid = 1'b1;
    #1;
    chk("st_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("st_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("st_hold_instr", out_instr, w0);
      chk("st_hold_addr", {22'd0, out_addr}, 32'd0);
      chk("st_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("st1_instr", out_instr, 32'h00210093);
    chk("st1_addr", {22'd0, out_addr}, 32'd1);
    set_fields(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd3);
    @(posedge clk); #1;
    chk("st2_instr", out_instr, 32'h00310093);
    chk("st2_addr", {22'd0, out_addr}, 32'd2);
    set_fields(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("st3_instr", out_instr, 32'h00410093);
    chk("st3_addr", {22'd0, out_addr}, 32'd3);

    // ---------------- asynchronous reset while a word is stalled
    send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("ms_valid", {31'd0, out_valid}, 32'd1);
    chk("ms_errcnt", {24'd0, err_count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ms_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("ms_rst_errcnt", {24'd0, err_count}, 32'd0);
    chk("ms_rst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ---------------- narrow counter: wrap, then clear on 3rd acceptance
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    set_fields(3'd5, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      chk("wrap_addr", {30'd0, out_addr2}, {30'd0, exp_a[i]});
    end
    in_valid2 = 1'b0;
    clear2 = 1'b1;
    @(posedge clk); #1;
    clear2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      clear2 = (i == 2);
      @(posedge clk); #1;
      chk("clr_addr", {30'd0, out_addr2}, {30'd0, exp_c[i]});
    end
    in_valid2 = 1'b0;
    clear2 = 1'b0;

    // ---------------- random legal round-trip through decoder model
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      sel = 3'(i % 6);
      case (sel)
        3'd0, 3'd1: begin v = int'($urandom_range(0, 4095)) - 2048; imm = v; end
        3'd2: begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; imm = v; end
        3'd4: begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; imm = v; end
        3'd3: imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom;
      endcase
      send(sel, rnd[6:0], rnd[11:7], rnd[16:12], rnd[21:17], rnd[24:22], rnd[31:25], imm);
      chk("rt_err", {31'd0, out_err}, 32'd0);
      chk("rt_opcode", {25'd0, out_instr[6:0]}, {25'd0, rnd[6:0]});
      if (sel == 3'd5)
        chk("rt_rfields", {7'd0, out_instr[31:7]},
            {7'd0, rnd[31:25], rnd[21:17], rnd[16:12], rnd[24:22], rnd[11:7]});
      else
        chk("rt_imm", dec_imm(sel, out_instr), imm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder: the inverse of the core's immediate-extraction path. It accepts decoded fields plus a 32-bit signed immediate over a valid/ready handshake, range-checks the immediate against the selected format, and scatters its bits into the correct instruction positions. It emits each encoded word with a sequential word address for instruction-memory preload. Used by the program loader and by the self-check bench that round-trips against the decoder.

## Interface
- ADDR_W, 10: width of the output word address and address counter.
- BASE_ADDR, 0: address given to the first word after reset or `clear`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous; counter returns to BASE_ADDR and err_count to 0.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- imm_sel  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R (no immediate); 110/111 illegal.
- opcode  in  7  placed at [6:0].
- rd  in  5  placed at [11:7] (I/U/J/R).
- rs1  in  5  placed at [19:15] (I/S/B/R).
- rs2  in  5  placed at [24:20] (S/B/R).
- funct3  in  3  placed at [14:12] (I/S/B/R).
- funct7  in  7  placed at [31:25] (R only).
- immediate  in  32  signed byte immediate; U-format takes the full value with [11:0] zero.
- out_valid  out  1  out_instr/out_addr/out_err valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  word address of this word.
- out_err  out  1  immediate out of range or illegal imm_sel.
- err_count  out  8  saturating count of accepted words with error.

## Operation
- Encoding (bit ranges of `immediate`):
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
- Range check sets the error flag on:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] set.
  - J: imm[31:20] not all equal, or imm[0] set.
  - U: imm[11:0] nonzero.
  - R: never.
  - Illegal sel: always, and out_instr = 0.
- On error, the word is still encoded from the truncated bits, with out_err=1. No word is dropped.
- Address counter:
  - Each accepted input takes the current counter value as its out_addr, then the counter increments.
  - The counter wraps modulo 2^ADDR_W.
- clear together with acceptance: the accepted word gets BASE_ADDR and the counter becomes BASE_ADDR+1. clear does not touch the output register.
- err_count increments on acceptance of an erroring word and saturates at 255.
- clear together with an erroring acceptance: err_count becomes 1.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, out_err 0, err_count 0, counter BASE_ADDR.
- in_ready = !out_valid || out_ready (combinational); 0 while reset is asserted.
- Transfer occurs when in_valid && in_ready.
- Latency is 1 cycle: the word is registered at the accept edge and out_valid is high the following cycle.
- Throughput: one word per cycle while out_ready is held high.
- Stall: while out_valid && !out_ready, all outputs hold stable and no input is accepted.
- out_valid falls after out_ready when no new input is accepted in that cycle.
- Reset mid-stall: the pending word is discarded and all state goes to reset values immediately.

## Test plan
- Reset, then I-type with opcode 0010011, rd=1, rs1=2, funct3=0, imm=-1 -> next cycle out_instr=0xFFF10093, out_addr=0, out_err=0.
- B-type with opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3. The same fields with imm=3 -> out_err=1 and err_count=1.
- J-type with opcode 1101111, rd=1, imm=2048 -> 0x001000EF. U-type with imm=0x12345001 -> out_err=1.
- Back-to-back stream of 4 words with out_ready held low for 3 cycles after the first -> first word held stable, in_ready=0, then out_addr 0,1,2,3 in order with no loss or duplication.
- ADDR_W=2: accept 5 words -> addresses 0,1,2,3,0. Assert clear on the 3rd acceptance -> addresses 0,1,0,1,2.
- Random legal fields for all formats, checked against a reference model that decodes out_instr and compares the recovered immediate with the input. Assert rst mid-stall -> out_valid=0 and err_count=0 asynchronously.
